// File: rtl/ahb_wb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_wb_pkg
// Shared definitions for the AHB-Lite to Wishbone bridge:
//   - ahb_wb_state_t : bridge FSM states
//   - HTRANS_* / HSIZE_* encodings of the AHB-Lite transfer type and size
//   - ahb_wb_sel()   : byte-lane enables for a given size and address
//   - ahb_wb_legal() : alignment / size legality of an access
// ---------------------------------------------------------------------------
package ahb_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } ahb_wb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Byte-lane enables. Only called for legal sizes; anything else maps to
    // a full word so the lanes never end up all-zero.
    function automatic logic [3:0] ahb_wb_sel(input logic [2:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] sel;
        case (size)
            HSIZE_BYTE: sel = 4'b0001 << addr_lo;
            HSIZE_HALF: sel = 4'b0011 << {addr_lo[1], 1'b0};
            default:    sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Sizes above a word and misaligned halves/words are rejected.
    function automatic logic ahb_wb_legal(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_wb_timeout.sv
// ---------------------------------------------------------------------------
// ahb_wb_timeout
// Counts cycles spent waiting for a Wishbone acknowledge and flags expiry.
// Only instantiated when AHB_WB_TIMEOUT_EN is defined.
// Ports:
//   clk_core, rst_core : clock, asynchronous active-high reset
//   start              : bridge is entering ACTIVE next cycle (clears count)
//   active             : bridge is in ACTIVE this cycle (count advances)
//   expired            : this is the TIMEOUT_CYCLES-th ACTIVE cycle
// ---------------------------------------------------------------------------
module ahb_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_core,
    input  logic rst_core,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The count is 0 in the first ACTIVE cycle, so the last allowed cycle
    // carries TIMEOUT_CYCLES-1; the increment out of it would reach the limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (active) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = active && (count_reg == CNT_LAST);

endmodule

// File: rtl/ahb_wishbone_bridge.sv
// ---------------------------------------------------------------------------
// ahb_wishbone_bridge
// AHB-Lite responder that turns each accepted transfer into one classic
// Wishbone cycle. One transfer outstanding; wait states via hready; illegal
// sizes/alignments answered with a two-cycle ERROR response.
// Optional feature macro: AHB_WB_TIMEOUT_EN -- abort an ACTIVE cycle with an
// ERROR after TIMEOUT_CYCLES cycles without wb_ack.
// Ports:
//   clk_core, rst_core           : clock, asynchronous active-high reset
//   haddr/hwrite/htrans/hsize    : AHB address phase
//   hwdata                       : AHB write data (data phase)
//   hexcl                        : unused
//   hrdata/hready/hresp/hexokay  : AHB response
//   wb_cyc/wb_stb/wb_we/wb_addr/
//   wb_sel/wb_data_out           : Wishbone request
//   wb_data_in/wb_ack            : Wishbone response
// ---------------------------------------------------------------------------
module ahb_wishbone_bridge
    import ahb_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hexcl,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic        hexokay,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_addr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_data_out,
    input  logic [31:0] wb_data_in,
    input  logic        wb_ack
);

    ahb_wb_state_t state_reg;
    logic          hready_reg;
    logic          hresp_reg;
    logic          cyc_reg;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [3:0]    sel_reg;
    logic [31:0]   hrdata_reg;

    logic htrans_start;
    logic accept;
    logic legal;
    logic start_active;
    logic timeout_hit;
    logic unused_hexcl;

    assign unused_hexcl = hexcl;

    // hready_reg is only high in IDLE, RESP and ERR2, which are exactly the
    // states that may take a new address phase.
    assign htrans_start = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign accept       = hready_reg && htrans_start;
    assign legal        = ahb_wb_legal(hsize, haddr[1:0]);
    assign start_active = accept && legal;

`ifdef AHB_WB_TIMEOUT_EN
    ahb_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .start    (start_active),
        .active   (state_reg == ST_ACTIVE),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_reg  <= ST_IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= 1'b0;
            cyc_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= 32'h0;
            sel_reg    <= 4'h0;
            hrdata_reg <= 32'h0;
        end else begin
            case (state_reg)
                ST_ACTIVE: begin
                    // An ack in the expiry cycle takes priority over timeout.
                    if (wb_ack) begin
                        hrdata_reg <= wb_data_in;
                        state_reg  <= ST_RESP;
                        cyc_reg    <= 1'b0;
                        hready_reg <= 1'b1;
                        hresp_reg  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_reg  <= ST_ERR1;
                        cyc_reg    <= 1'b0;
                        hready_reg <= 1'b0;
                        hresp_reg  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_reg  <= ST_ERR2;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b1;
                end
                default: begin
                    // IDLE, RESP and ERR2 all behave as "ready for a new
                    // address phase"; any stray encoding recovers here too.
                    if (accept) begin
                        we_reg   <= hwrite;
                        addr_reg <= haddr;
                        sel_reg  <= ahb_wb_sel(hsize, haddr[1:0]);
                        if (legal) begin
                            state_reg  <= ST_ACTIVE;
                            cyc_reg    <= 1'b1;
                            hready_reg <= 1'b0;
                            hresp_reg  <= 1'b0;
                        end else begin
                            state_reg  <= ST_ERR1;
                            cyc_reg    <= 1'b0;
                            hready_reg <= 1'b0;
                            hresp_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg  <= ST_IDLE;
                        cyc_reg    <= 1'b0;
                        hready_reg <= 1'b1;
                        hresp_reg  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hready      = hready_reg;
    assign hresp       = hresp_reg;
    assign hrdata      = hrdata_reg;
    assign hexokay     = 1'b0;
    assign wb_cyc      = cyc_reg;
    assign wb_stb      = cyc_reg;
    assign wb_we       = we_reg;
    assign wb_addr     = addr_reg;
    assign wb_sel      = sel_reg;
    // AHB keeps hwdata stable through the wait states, so no copy is needed.
    assign wb_data_out = hwdata;

endmodule

// File: tb/tb_ahb_wishbone_bridge.sv
`timescale 1ns/1ps
module tb_ahb_wishbone_bridge;
    import ahb_wb_pkg::*;

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hexcl;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        hexokay;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_data_out;
    logic [31:0] wb_data_in;
    logic        wb_ack;

    always #5 clk_core = ~clk_core;

    ahb_wishbone_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .haddr       (haddr),
        .hwrite      (hwrite),
        .htrans      (htrans),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .hexcl       (hexcl),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .hexokay     (hexokay),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_sel      (wb_sel),
        .wb_data_out (wb_data_out),
        .wb_data_in  (wb_data_in),
        .wb_ack      (wb_ack)
    );

    typedef struct {
        logic        resp;
        logic        chk_data;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] addr;
    } ahb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
    } wb_exp_t;

    ahb_exp_t ahb_q[$];
    wb_exp_t  wb_q[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] tr_addr [16];
    logic        tr_wr   [16];
    logic [2:0]  tr_size [16];
    logic [31:0] tr_wd   [16];
    int          n_tr = 0;
    logic        dp_on = 1'b0;
    logic [1:0]  idle_tr = HTRANS_IDLE;

    logic [31:0] mem [256];
    int          ack_wait = 1;

    int stb_run = 0, last_stb_run = 0, low_run = 0, last_low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string act, input string req);
        total++;
        bad++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    task automatic add(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] sel, input logic resp,
                       input logic [31:0] rd, input int waits);
        ahb_exp_t e;
        wb_exp_t  w;
        tr_addr[n_tr] = a;
        tr_wr[n_tr]   = wr;
        tr_size[n_tr] = sz;
        tr_wd[n_tr]   = wd;
        n_tr++;
        e.resp = resp; e.chk_data = !wr && !resp; e.rdata = rd; e.waits = waits; e.addr = a;
        ahb_q.push_back(e);
        if (!resp) begin
            w.addr = a; w.sel = sel; w.we = wr; w.data = wd;
            wb_q.push_back(w);
        end
    endtask

    task automatic drive_addr(input int i);
        if (i < n_tr) begin
            haddr  = tr_addr[i];
            hwrite = tr_wr[i];
            hsize  = tr_size[i];
            htrans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end else begin
            haddr  = 32'h0;
            hwrite = 1'b0;
            hsize  = 3'd0;
            htrans = idle_tr;
        end
    endtask

    // Pipelined AHB-Lite initiator: runs the queued transfers back-to-back.
    task automatic run_all();
        int   pend;
        int   nxt;
        int   guard;
        logic hr;
        pend = -1; nxt = 0; guard = 0;
        drive_addr(nxt);
        while (pend >= 0 || nxt < n_tr) begin
            @(negedge clk_core);
            hr = hready;
            @(posedge clk_core);
            #1;
            guard++;
            if (hr) begin
                if (nxt < n_tr) begin pend = nxt; nxt++; end
                else pend = -1;
                dp_on  = (pend >= 0);
                hwdata = (pend >= 0 && tr_wr[pend]) ? tr_wd[pend] : 32'h0;
                drive_addr(nxt);
            end
            if (guard > 2000) begin
                fail("master_guard", "no_completion", "completion");
                dp_on = 1'b0;
                break;
            end
        end
        n_tr = 0;
    endtask

    // Wishbone memory: ack ack_wait cycles after strobe is first seen (0 = never).
    initial begin
        int   stb_cnt;
        logic nack;
        stb_cnt = 0;
        wb_ack = 1'b0;
        wb_data_in = 32'h0;
        forever begin
            @(negedge clk_core);
            nack = 1'b0;
            if (rst_core) begin
                stb_cnt = 0;
            end else if (wb_cyc && wb_stb) begin
                if (wb_ack) begin
                    if (wb_we)
                        for (int b = 0; b < 4; b++)
                            if (wb_sel[b]) mem[wb_addr[9:2]][8*b +: 8] = wb_data_out[8*b +: 8];
                    stb_cnt = 0;
                end else begin
                    stb_cnt++;
                    if (ack_wait != 0 && stb_cnt >= ack_wait) nack = 1'b1;
                end
            end
            @(posedge clk_core);
            #1;
            wb_ack     = nack && !rst_core;
            wb_data_in = nack ? mem[wb_addr[9:2]] : 32'h0;
        end
    end

    // Run-length tracking of wb_stb high and wb_cyc low.
    initial begin
        forever begin
            @(negedge clk_core);
            if (wb_stb) stb_run++;
            else if (stb_run > 0) begin last_stb_run = stb_run; stb_run = 0; end
            if (!wb_cyc) low_run++;
            else if (low_run > 0) begin last_low_run = low_run; low_run = 0; end
        end
    end

    // AHB response monitor.
    initial begin
        int       wcnt;
        ahb_exp_t e;
        wcnt = 0;
        forever begin
            @(negedge clk_core);
            if (rst_core) begin
                wcnt = 0;
            end else if (dp_on) begin
                if (!hready) begin
                    wcnt++;
                    if (hresp) begin
                        if (ahb_q.size() == 0) fail("err1_unexpected", "hresp=1", "no_transfer");
                        else check("err1_hresp", {31'b0, hresp}, {31'b0, ahb_q[0].resp});
                    end
                end else begin
                    if (ahb_q.size() == 0) begin
                        fail("ahb_unexpected", "completion", "none");
                    end else begin
                        e = ahb_q.pop_front();
                        check("hresp", {31'b0, hresp}, {31'b0, e.resp});
                        check("waits", wcnt, e.waits);
                        if (e.chk_data) check("hrdata", hrdata, e.rdata);
                        $display("xfer addr=%h resp=%0d waits=%0d hrdata=%h",
                                 e.addr, hresp, wcnt, hrdata);
                    end
                    wcnt = 0;
                end
            end
        end
    end

    // Wishbone request monitor: every strobed cycle must match the head entry.
    initial begin
        forever begin
            @(negedge clk_core);
            if (!rst_core && wb_cyc && wb_stb) begin
                if (wb_q.size() == 0) begin
                    fail("wb_unexpected", "wb_stb=1", "no_cycle");
                end else begin
                    check("wb_addr", wb_addr, wb_q[0].addr);
                    check("wb_sel", {28'b0, wb_sel}, {28'b0, wb_q[0].sel});
                    check("wb_we", {31'b0, wb_we}, {31'b0, wb_q[0].we});
                    if (wb_q[0].we) check("wb_data_out", wb_data_out, wb_q[0].data);
                    if (wb_ack) void'(wb_q.pop_front());
                end
            end
        end
    end

    initial begin
        wb_exp_t w;
        haddr = 32'h0; hwrite = 1'b0; htrans = HTRANS_IDLE; hsize = 3'd0;
        hwdata = 32'h0; hexcl = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'hDEADBEEF;   // 0x40
        mem[64] = 32'h11223344;   // 0x100

        repeat (3) @(posedge clk_core);
        #1;
        check("rst_wb_cyc", {31'b0, wb_cyc}, 32'd0);
        check("rst_wb_stb", {31'b0, wb_stb}, 32'd0);
        check("rst_wb_we", {31'b0, wb_we}, 32'd0);
        check("rst_wb_addr", wb_addr, 32'h0);
        check("rst_wb_sel", {28'b0, wb_sel}, 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_hready", {31'b0, hready}, 32'd1);
        check("rst_hresp", {31'b0, hresp}, 32'd0);
        check("rst_hexokay", {31'b0, hexokay}, 32'd0);
        rst_core = 1'b0;
        @(posedge clk_core);
        #1;

        // Word read, ack one cycle after strobe: two wait states.
        add(32'h40, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 2);
        run_all();

        // Byte write to lane 3, then read back the merged word.
        add(32'h103, 1'b1, HSIZE_BYTE, 32'hAB000000, 4'b1000, 1'b0, 32'h0, 2);
        add(32'h100, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hAB223344, 2);
        run_all();

        // Read then pipelined write issued in the RESP cycle.
        last_low_run = 99;
        add(32'h40, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 2);
        add(32'h44, 1'b1, HSIZE_WORD, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0, 2);
        run_all();
        check("pipeline_cyc_gap", last_low_run, 1);
        add(32'h44, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hCAFEF00D, 2);
        run_all();

        // Half write to upper half, readback, byte read; BUSY while idle.
        idle_tr = HTRANS_BUSY;
        add(32'h102, 1'b1, HSIZE_HALF, 32'h5A5A0000, 4'b1100, 1'b0, 32'h0, 2);
        add(32'h100, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'h5A5A3344, 2);
        add(32'h41, 1'b0, HSIZE_BYTE, 32'h0, 4'b0010, 1'b0, 32'hDEADBEEF, 2);
        run_all();
        repeat (2) @(posedge clk_core);
        #1;
        check("busy_hready", {31'b0, hready}, 32'd1);
        idle_tr = HTRANS_IDLE;

        // Illegal accesses back-to-back, then a legal read from ERR2.
        add(32'h101, 1'b0, HSIZE_HALF, 32'h0, 4'b0000, 1'b1, 32'h0, 1);
        add(32'h42, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 1'b1, 32'h0, 1);
        add(32'h0, 1'b1, 3'd3, 32'h0, 4'b0000, 1'b1, 32'h0, 1);
        add(32'h40, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 2);
        run_all();

`ifdef AHB_WB_TIMEOUT_EN
        // No ack: 8 strobe cycles, ERR1 in cycle 9, ERR2 completes.
        ack_wait = 0;
        add(32'h40, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b1, 32'h0, 9);
        run_all();
        check("timeout_stb_run", last_stb_run, 8);
        wb_q.delete();
        ack_wait = 1;
`else
        // Ack after 100 strobe cycles: completes OKAY after 101 wait states.
        ack_wait = 100;
        add(32'h44, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hCAFEF00D, 101);
        run_all();
        check("late_stb_run", last_stb_run, 101);
        ack_wait = 1;
`endif

        // Reset while ACTIVE.
        ack_wait = 0;
        w.addr = 32'h80; w.sel = 4'b1111; w.we = 1'b0; w.data = 32'h0;
        wb_q.push_back(w);
        haddr = 32'h80; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        @(posedge clk_core);
        #1;
        htrans = HTRANS_IDLE;
        repeat (3) @(posedge clk_core);
        #1;
        check("pre_reset_stb", {31'b0, wb_stb}, 32'd1);
        rst_core = 1'b1;
        #1;
        check("mid_rst_wb_cyc", {31'b0, wb_cyc}, 32'd0);
        check("mid_rst_wb_stb", {31'b0, wb_stb}, 32'd0);
        check("mid_rst_hready", {31'b0, hready}, 32'd1);
        check("mid_rst_hrdata", hrdata, 32'h0);
        check("mid_rst_wb_sel", {28'b0, wb_sel}, 32'd0);
        wb_q.delete();
        repeat (2) @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        ack_wait = 1;
        @(posedge clk_core);
        #1;
        add(32'h44, 1'b0, HSIZE_WORD, 32'h0, 4'b1111, 1'b0, 32'hCAFEF00D, 2);
        run_all();

        repeat (3) @(posedge clk_core);
        #1;
        check("ahb_q_drained", ahb_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("end_hexokay", {31'b0, hexokay}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
